// File: rtl/fix_msg_serializer.sv
// rtl/fix_msg_serializer.sv - FIX tag/value pair to ASCII byte stream serializer with checksum trailer
module fix_msg_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         pair_valid_i,
  output logic         pair_ready_o,
  input  logic [31:0]  tag_i,
  input  logic [255:0] value_i,
  input  logic         last_i,
  output logic [7:0]   data_o,
  output logic         data_valid_o,
  input  logic         data_ready_i,
  output logic         start_message_o,
  output logic         end_message_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAG, S_EQ, S_VAL, S_SOH, S_CK_TAG, S_CK_DIG, S_CK_SOH
  } state_t;

  function automatic logic [2:0] tag_len(input logic [31:0] t);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++)
      if (t[8*i +: 8] != 8'h00) n = 3'(i + 1);
    return n;
  endfunction

  function automatic logic [5:0] val_len(input logic [255:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++)
      if (v[8*i +: 8] != 8'h00) n = 6'(i + 1);
    return n;
  endfunction

  // Decimal split of the checksum by compare/subtract: {hundreds, tens, units}.
  function automatic logic [11:0] cs_digits(input logic [7:0] c);
    logic [7:0] r;
    logic [3:0] h;
    logic [3:0] t;
    r = c;
    h = 4'd0;
    if (r >= 8'd200) begin
      h = 4'd2;
      r = r - 8'd200;
    end else if (r >= 8'd100) begin
      h = 4'd1;
      r = r - 8'd100;
    end
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        t = t + 4'd1;
        r = r - 8'd10;
      end
    end
    return {h, t, r[3:0]};
  endfunction

  state_t       state;
  logic [31:0]  tag_q;
  logic [255:0] val_q;
  logic         last_q;
  logic [5:0]   nval_q;
  logic [4:0]   idx;
  logic [7:0]   cs;
  logic         msg_open;

  logic         accept;
  logic         xfer;
  logic [2:0]   ntag_in;
  logic [5:0]   nval_in;
  logic [1:0]   ntag_m1;
  logic [4:0]   nval_m1;
  logic [4:0]   idx_dn;
  logic [11:0]  digits;

  assign pair_ready_o = (state == S_IDLE) && !rst;
  assign accept       = pair_valid_i && pair_ready_o;
  assign xfer         = data_valid_o && data_ready_i;
  assign ntag_in      = tag_len(tag_i);
  assign nval_in      = val_len(value_i);
  assign ntag_m1      = 2'(ntag_in - 3'd1);
  assign nval_m1      = 5'(nval_q - 6'd1);
  assign idx_dn       = idx - 5'd1;
  assign digits       = cs_digits(cs);

  // data_o always holds the byte being offered; a transfer loads the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      tag_q           <= '0;
      val_q           <= '0;
      last_q          <= 1'b0;
      nval_q          <= '0;
      idx             <= '0;
      cs              <= '0;
      msg_open        <= 1'b0;
      data_o          <= 8'h00;
      data_valid_o    <= 1'b0;
      start_message_o <= 1'b0;
      end_message_o   <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (xfer) start_message_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (ntag_in == 3'd0) begin
              err_o <= 1'b1;
            end else begin
              tag_q        <= tag_i;
              val_q        <= value_i;
              last_q       <= last_i;
              nval_q       <= nval_in;
              idx          <= {3'b000, ntag_m1};
              data_o       <= tag_i[{ntag_m1, 3'b000} +: 8];
              data_valid_o <= 1'b1;
              state        <= S_TAG;
              if (!msg_open) begin
                start_message_o <= 1'b1;
                msg_open        <= 1'b1;
              end
            end
          end
        end
        S_TAG: begin
          if (xfer) begin
            cs <= cs + data_o;
            if (idx == 5'd0) begin
              data_o <= 8'h3D;
              state  <= S_EQ;
            end else begin
              idx    <= idx_dn;
              data_o <= tag_q[{idx_dn[1:0], 3'b000} +: 8];
            end
          end
        end
        S_EQ: begin
          if (xfer) begin
            cs <= cs + data_o;
            if (nval_q == 6'd0) begin
              data_o <= 8'h01;
              state  <= S_SOH;
            end else begin
              idx    <= nval_m1;
              data_o <= val_q[{nval_m1, 3'b000} +: 8];
              state  <= S_VAL;
            end
          end
        end
        S_VAL: begin
          if (xfer) begin
            cs <= cs + data_o;
            if (idx == 5'd0) begin
              data_o <= 8'h01;
              state  <= S_SOH;
            end else begin
              idx    <= idx_dn;
              data_o <= val_q[{idx_dn, 3'b000} +: 8];
            end
          end
        end
        S_SOH: begin
          if (xfer) begin
            cs <= cs + data_o;
            if (last_q) begin
              data_o <= 8'h31;
              idx    <= 5'd2;
              state  <= S_CK_TAG;
            end else begin
              data_valid_o <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end
        S_CK_TAG: begin
          // idx 2,1,0 offer "1", "0", "="; cs is final and frozen from here on.
          if (xfer) begin
            if (idx == 5'd2) begin
              data_o <= 8'h30;
              idx    <= idx_dn;
            end else if (idx == 5'd1) begin
              data_o <= 8'h3D;
              idx    <= idx_dn;
            end else begin
              data_o <= 8'h30 + {4'h0, digits[11:8]};
              idx    <= 5'd2;
              state  <= S_CK_DIG;
            end
          end
        end
        S_CK_DIG: begin
          if (xfer) begin
            if (idx == 5'd2) begin
              data_o <= 8'h30 + {4'h0, digits[7:4]};
              idx    <= idx_dn;
            end else if (idx == 5'd1) begin
              data_o <= 8'h30 + {4'h0, digits[3:0]};
              idx    <= idx_dn;
            end else begin
              data_o        <= 8'h01;
              end_message_o <= 1'b1;
              state         <= S_CK_SOH;
            end
          end
        end
        S_CK_SOH: begin
          if (xfer) begin
            data_valid_o  <= 1'b0;
            end_message_o <= 1'b0;
            cs            <= 8'h00;
            msg_open      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_msg_serializer.sv
// tb/tb_fix_msg_serializer.sv - directed self-checking bench for fix_msg_serializer
module tb_fix_msg_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         pair_valid;
  logic         pair_ready;
  logic [31:0]  tag;
  logic [255:0] value;
  logic         last;
  logic [7:0]   data;
  logic         data_valid;
  logic         data_ready;
  logic         start_message;
  logic         end_message;
  logic         err;

  int checks = 0;
  int failures = 0;
  bit rand_mode = 1'b0;

  logic [7:0] got_b[$];
  bit         got_s[$];
  bit         got_e[$];
  logic [7:0] exp_b[$];
  int         model_sum = 0;
  logic [7:0] held_b;
  bit         held_v = 1'b0;

  fix_msg_serializer dut (
    .clk             (clk),
    .rst             (rst),
    .pair_valid_i    (pair_valid),
    .pair_ready_o    (pair_ready),
    .tag_i           (tag),
    .value_i         (value),
    .last_i          (last),
    .data_o          (data),
    .data_valid_o    (data_valid),
    .data_ready_i    (data_ready),
    .start_message_o (start_message),
    .end_message_o   (end_message),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      data_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte collector plus hold-while-stalled monitor.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall valid", {31'd0, data_valid}, 32'd1);
        check("stall hold", {24'd0, data}, {24'd0, held_b});
      end
      if (data_valid && data_ready) begin
        got_b.push_back(data);
        got_s.push_back(start_message);
        got_e.push_back(end_message);
      end
      held_v = data_valid && !data_ready;
      held_b = data;
    end
  end

  task automatic clear_all();
    got_b.delete();
    got_s.delete();
    got_e.delete();
    exp_b.delete();
  endtask

  task automatic push_exp(input logic [7:0] b, input bit body);
    exp_b.push_back(b);
    if (body) model_sum += int'(b);
  endtask

  task automatic model_field(input logic [31:0] t, input logic [255:0] v, input bit l);
    int nt;
    int nv;
    int s;
    nt = 0;
    nv = 0;
    for (int i = 0; i < 4; i++) if (t[8*i +: 8] != 8'h00) nt = i + 1;
    for (int i = 0; i < 32; i++) if (v[8*i +: 8] != 8'h00) nv = i + 1;
    for (int i = nt - 1; i >= 0; i--) push_exp(t[8*i +: 8], 1'b1);
    push_exp(8'h3D, 1'b1);
    for (int i = nv - 1; i >= 0; i--) push_exp(v[8*i +: 8], 1'b1);
    push_exp(8'h01, 1'b1);
    if (l) begin
      s = model_sum % 256;
      push_exp(8'h31, 1'b0);
      push_exp(8'h30, 1'b0);
      push_exp(8'h3D, 1'b0);
      push_exp(8'(48 + s / 100), 1'b0);
      push_exp(8'(48 + (s / 10) % 10), 1'b0);
      push_exp(8'(48 + s % 10), 1'b0);
      push_exp(8'h01, 1'b0);
      model_sum = 0;
    end
  endtask

  task automatic send_pair(input logic [31:0] t, input logic [255:0] v, input bit l);
    int n;
    n = 0;
    @(negedge clk);
    while (!pair_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("pair_ready timeout", 32'd0, 32'd1);
    tag = t;
    value = v;
    last = l;
    pair_valid = 1'b1;
    @(posedge clk);
    #1;
    pair_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(pair_ready && !data_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("done timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string name, input bit first, input bit trailer);
    int n;
    int ns;
    int ne;
    check({name, " length"}, got_b.size(), exp_b.size());
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++)
      check({name, " byte"}, {24'd0, got_b[i]}, {24'd0, exp_b[i]});
    ns = 0;
    ne = 0;
    foreach (got_s[i]) ns += int'(got_s[i]);
    foreach (got_e[i]) ne += int'(got_e[i]);
    check({name, " start count"}, ns, {31'd0, first});
    check({name, " end count"}, ne, {31'd0, trailer});
    if (got_b.size() > 0) begin
      check({name, " start on byte 0"}, {31'd0, got_s[0]}, {31'd0, first});
      check({name, " end on final byte"}, {31'd0, got_e[got_e.size()-1]}, {31'd0, trailer});
    end
  endtask

  task automatic check_digits(input string name, input logic [23:0] ascii);
    int n;
    n = got_b.size();
    if (n >= 4) check({name, " digits"}, {8'd0, got_b[n-4], got_b[n-3], got_b[n-2]}, {8'd0, ascii});
    else check({name, " digits present"}, n, 32'd4);
  endtask

  task automatic run_field_a(input string name);
    clear_all();
    exp_b = '{8'h33, 8'h35, 8'h3D, 8'h41, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h32, 8'h33, 8'h31, 8'h01};
    send_pair(32'h0000_3335, 256'h41, 1'b1);
    @(negedge clk);
    check({name, " first byte valid"}, {31'd0, data_valid}, 32'd1);
    check({name, " first byte"}, {24'd0, data}, 32'h33);
    wait_done();
    compare_stream(name, 1'b1, 1'b1);
  endtask

  logic [255:0] v32;

  initial begin
    rst = 1'b1;
    pair_valid = 1'b0;
    tag = '0;
    value = '0;
    last = 1'b0;
    for (int i = 0; i < 32; i++) v32[8*i +: 8] = 8'(8'h41 + i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pair_ready", {31'd0, pair_ready}, 32'd0);
    check("reset data_valid", {31'd0, data_valid}, 32'd0);
    check("reset data", {24'd0, data}, 32'd0);
    check("reset start", {31'd0, start_message}, 32'd0);
    check("reset end", {31'd0, end_message}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    #1;
    check("pair_ready after reset", {31'd0, pair_ready}, 32'd1);

    run_field_a("single");

    clear_all();
    model_field(32'h38, 256'("FIX.4.2"), 1'b0);
    model_field(32'h3335, 256'h44, 1'b1);
    send_pair(32'h38, 256'("FIX.4.2"), 1'b0);
    send_pair(32'h3335, 256'h44, 1'b1);
    wait_done();
    compare_stream("two field", 1'b1, 1'b1);
    check_digits("two field", 24'h303039);

    clear_all();
    model_field(32'h3434, v32, 1'b1);
    send_pair(32'h3434, v32, 1'b1);
    wait_done();
    compare_stream("wide ready", 1'b1, 1'b1);

    clear_all();
    rand_mode = 1'b1;
    model_field(32'h3434, v32, 1'b1);
    send_pair(32'h3434, v32, 1'b1);
    wait_done();
    rand_mode = 1'b0;
    compare_stream("wide random", 1'b1, 1'b1);

    clear_all();
    model_field(32'h3538, 256'h0, 1'b0);
    exp_b = '{8'h35, 8'h38, 8'h3D, 8'h01};
    send_pair(32'h3538, 256'h0, 1'b0);
    wait_done();
    compare_stream("empty value", 1'b1, 1'b0);

    clear_all();
    send_pair(32'h0, 256'h41, 1'b1);
    @(negedge clk);
    check("zero tag err", {31'd0, err}, 32'd1);
    check("zero tag ready", {31'd0, pair_ready}, 32'd1);
    check("zero tag valid", {31'd0, data_valid}, 32'd0);
    @(negedge clk);
    check("zero tag err pulse", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero tag bytes", got_b.size(), 32'd0);

    clear_all();
    model_field(32'h31, 256'h0, 1'b1);
    send_pair(32'h31, 256'h0, 1'b1);
    wait_done();
    compare_stream("close after err", 1'b0, 1'b1);
    check_digits("close after err", 24'h303236);

    clear_all();
    model_field(32'h41, 256'h4140, 1'b1);
    send_pair(32'h41, 256'h4140, 1'b1);
    wait_done();
    compare_stream("cs zero", 1'b1, 1'b1);
    check_digits("cs zero", 24'h303030);

    clear_all();
    model_field(32'h41, 256'h4145, 1'b1);
    send_pair(32'h41, 256'h4145, 1'b1);
    wait_done();
    compare_stream("cs five", 1'b1, 1'b1);
    check_digits("cs five", 24'h303035);

    clear_all();
    send_pair(32'h31, v32, 1'b1);
    repeat (3) @(negedge clk);
    check("mid value byte", {24'd0, data}, 32'h60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort data_valid", {31'd0, data_valid}, 32'd0);
    check("abort pair_ready", {31'd0, pair_ready}, 32'd1);
    model_sum = 0;
    run_field_a("after abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fix_msg_serializer.md
# fix_msg_serializer

Transmit-side counterpart of the FIX tag/value extraction path. Accepts one tag/value pair per handshake, serializes it as ASCII `tag=value<SOH>` onto a byte stream, and keeps a running byte checksum. After the pair flagged last, it appends the trailer `10=NNN<SOH>`. It sits between the tag/value FIFOs of the outbound message path and the byte-level line interface.

## Interface
- No parameters. Widths are fixed: tag 32 bits (4 ASCII chars), value 256 bits (32 ASCII chars).
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pair_valid_i  input  1  tag_i, value_i and last_i are valid
- pair_ready_o  output  1  block can accept a pair
- tag_i  input  32  tag ASCII, right-justified; leading 0x00 bytes are not sent
- value_i  input  256  value ASCII, right-justified; leading 0x00 bytes are not sent
- last_i  input  1  pair is the final body field; the checksum trailer follows it
- data_o  output  8  serialized byte
- data_valid_o  output  1  data_o holds a byte
- data_ready_i  input  1  downstream accepts data_o
- start_message_o  output  1  high with the first byte of a message (checksum was zero before it)
- end_message_o  output  1  high with the trailer SOH byte
- err_o  output  1  one-cycle pulse: tag_i was all-zero when accepted

## Operation
- A pair is accepted when pair_valid_i && pair_ready_o. On accept, tag_i, value_i and last_i are latched.
- Tag length ntag is the index of the highest nonzero byte, plus one (0..4). Value length nval is computed the same way (0..32). Bytes are sent most-significant first.
- States:
  - IDLE: pair_ready_o=1. Accept moves to TAG. If ntag=0, stay in IDLE, pulse err_o, emit nothing, leave the checksum unchanged; last_i is ignored.
  - TAG: emit ntag bytes, then go to EQ.
  - EQ: emit 0x3D, then go to VAL, or to SOH if nval=0.
  - VAL: emit nval bytes, then go to SOH.
  - SOH: emit 0x01, then go to CK_TAG if last, else IDLE.
  - CK_TAG: emit 0x31, 0x30, 0x3D, then go to CK_DIG.
  - CK_DIG: emit three digits, then go to CK_SOH.
  - CK_SOH: emit 0x01 with end_message_o=1, clear the checksum, go to IDLE.
- Checksum: an 8-bit register, incremented modulo 256 by every byte transferred from TAG through SOH. CK_* bytes are excluded.
- Digits: hundreds = cs/100, tens = (cs%100)/10, units = cs%10, each sent as 0x30+digit. Digits are derived by compare/subtract on the frozen checksum; no divider.
- A byte counts as transferred only on data_valid_o && data_ready_i.
- start_message_o is asserted for the whole time the first byte of a message is presented. The first byte of a message is the first TAG byte after reset or after CK_SOH.
- Reset mid-message: the partial message is abandoned, the checksum is cleared, and the state returns to IDLE. Nothing resumes.

## Timing
- Reset values: pair_ready_o=0 during reset and 1 in the first cycle after reset. data_o=0x00, data_valid_o=0, start_message_o=0, end_message_o=0, err_o=0.
- data_o and data_valid_o are registered. Once data_valid_o is high, data_o is held stable until data_ready_i.
- Accept in cycle N puts the first tag byte on data_o in cycle N+1.
- With data_ready_i held high, one byte transfers per cycle.
- A body field takes ntag+nval+2 transfer cycles. The trailer takes 7 transfer cycles.
- pair_ready_o is 0 from the accept cycle until the cycle after the final SOH of that field, or the trailer SOH, is transferred. Minimum gap between accepts is ntag+nval+3 cycles.
- An err_o accept does not drop pair_ready_o; the block can accept again in the next cycle.
- data_ready_i low stalls every state with no byte lost or duplicated. The checksum does not change while stalled.

## Test plan
- Single field, always ready: tag 0x00003335, value "A" (0x41), last=1. Required stream: 33 35 3D 41 01 31 30 3D 32 33 31 01, i.e. checksum 231. start_message_o on byte 0, end_message_o on byte 11.
- Two fields "8=FIX.4.2" then "35=D" (last): bytes match the ASCII exactly. Trailer digits equal the reference-model sum of all body bytes mod 256, and the checksum wraps past 255 correctly.
- Random data_ready_i (50% low) on a 32-byte value: stream identical to the always-ready run, data_o stable while data_valid_o && !data_ready_i.
- Empty value (value_i=0), tag "58": stream 35 38 3D 01. A zero tag: err_o pulses, no bytes emitted, pair_ready_o stays 1.
- Checksum 0 and 5 cases: digits "000" and "005", leading zeros always sent.
- Assert rst during a VAL byte: next cycle data_valid_o=0 and pair_ready_o=1. The next message starts with a fresh checksum and start_message_o.
